// File: rtl/conv_window_fetch.sv
// conv_window_fetch: walks a row-major image and re-times paired memory reads
// into a KxK stride-1 window tap stream, two taps per beat, valid/ready out.
// Optional build macro: WINDOW_PAD_EN ("same" padding, out-of-image taps read as 0).

// Per-lane tap address generator: flat address (mod 2^ADDR_W) plus out-of-image flag.
module cwf_tap_lane #(
  parameter int ADDR_W = 16,
  parameter int IMG_W  = 32,
  parameter int IMG_H  = 32,
  parameter int PAD    = 0,
  parameter int CW     = 6,
  parameter int KW     = 3
) (
  input  logic [ADDR_W-1:0] base,
  input  logic [CW-1:0]     wy,
  input  logic [CW-1:0]     wx,
  input  logic [KW-1:0]     ky,
  input  logic [KW-1:0]     kx,
  output logic [ADDR_W-1:0] addr,
  output logic              oob
);
  int row, col;

  // Signed pixel coordinate; negative offsets simply wrap in the address.
  always_comb begin
    row  = int'(wy) + int'(ky) - PAD;
    col  = int'(wx) + int'(kx) - PAD;
    oob  = (row < 0) || (row >= IMG_H) || (col < 0) || (col >= IMG_W);
    addr = base + ADDR_W'(row * IMG_W + col);
  end
endmodule

module conv_window_fetch #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 18,
  parameter int IMG_W  = 32,
  parameter int IMG_H  = 32,
  parameter int K      = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  output logic [ADDR_W-1:0] read_addr_a,
  output logic [ADDR_W-1:0] read_addr_b,
  input  logic [DATA_W-1:0] read_data_a,
  input  logic [DATA_W-1:0] read_data_b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_a,
  output logic [DATA_W-1:0] out_b,
  output logic              out_b_valid,
  output logic              out_wlast,
  output logic              busy,
  output logic              done
);
  localparam int TAPS      = K * K;
  localparam int BEATS     = (TAPS + 1) / 2;
  localparam int NUM_LANES = 2;
  localparam int STAGES    = 1;
`ifdef WINDOW_PAD_EN
  localparam int PAD     = K / 2;
  localparam int WX_LAST = IMG_W - 1;
  localparam int WY_LAST = IMG_H - 1;
`else
  localparam int PAD     = 0;
  localparam int WX_LAST = IMG_W - K;
  localparam int WY_LAST = IMG_H - K;
`endif
  localparam int CW = $clog2(((IMG_W > IMG_H) ? IMG_W : IMG_H) + 1);
  localparam int KW = 3;
  localparam int JW = $clog2(BEATS + 1);

  typedef struct packed { logic [KW-1:0] ky; logic [KW-1:0] kx; } tap_t;
  typedef struct packed { logic [DATA_W-1:0] a; logic [DATA_W-1:0] b; logic bv; logic last; } beat_t;
  typedef struct packed { logic bv; logic last; logic oob_a; logic oob_b; } meta_t;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  function automatic tap_t tap_inc(input tap_t t);
    tap_t r;
    if (t.kx == KW'(K - 1)) begin r.ky = t.ky + 1'b1; r.kx = '0; end
    else begin r.ky = t.ky; r.kx = t.kx + 1'b1; end
    return r;
  endfunction

  state_t state, state_next;
  logic [ADDR_W-1:0] base_q, cur_base;
  logic [CW-1:0] wx, wy;
  tap_t tap0;
  logic [JW-1:0] j;
  logic issued_all, issue, last_beat, last_win, bv_cur, can_issue;
  logic [STAGES:0] vld_pipe;
  meta_t [STAGES:0] meta_pipe;
  tap_t [NUM_LANES-1:0] lane_tap;
  logic [NUM_LANES-1:0][ADDR_W-1:0] lane_addr;
  logic [NUM_LANES-1:0] lane_oob;
  beat_t [1:0] fifo;
  beat_t land, head;
  logic wr_ptr, rd_ptr, pop, spop, push;
  logic [1:0] cnt, cnt_next;

  assign cur_base    = (state == IDLE) ? base_addr : base_q;
  assign lane_tap[0] = tap0;
  assign lane_tap[1] = tap_inc(tap0);

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    cwf_tap_lane #(.ADDR_W(ADDR_W), .IMG_W(IMG_W), .IMG_H(IMG_H), .PAD(PAD), .CW(CW), .KW(KW)) u_lane (
      .base(cur_base), .wy(wy), .wx(wx), .ky(lane_tap[l].ky), .kx(lane_tap[l].kx),
      .addr(lane_addr[l]), .oob(lane_oob[l]));
  end

  assign last_beat = (j == JW'(BEATS - 1));
  assign last_win  = (wx == CW'(WX_LAST)) && (wy == CW'(WY_LAST));
  assign bv_cur    = (2 * int'(j) + 1) < TAPS;

  // Landing beat: data arrives one cycle after its address; padded slots read as 0.
  assign land.a    = meta_pipe[1].oob_a ? '0 : read_data_a;
  assign land.b    = (!meta_pipe[1].bv || meta_pipe[1].oob_b) ? '0 : read_data_b;
  assign land.bv   = meta_pipe[1].bv;
  assign land.last = meta_pipe[1].last;

  // Fall-through: an empty FIFO presents the landing beat directly.
  assign head      = (cnt != 2'd0) ? fifo[rd_ptr] : land;
  assign out_valid = (cnt != 2'd0) || vld_pipe[1];
  assign pop       = out_valid && out_ready;
  assign spop      = pop && (cnt != 2'd0);
  assign push      = vld_pipe[1] && !(pop && (cnt == 2'd0));
  assign cnt_next  = cnt + 2'(push) - 2'(spop);
  assign can_issue = (3'(cnt_next) + 3'(vld_pipe[0])) < 3'd2;

  assign out_a       = out_valid ? head.a : '0;
  assign out_b       = out_valid ? head.b : '0;
  assign out_b_valid = out_valid && head.bv;
  assign out_wlast   = out_valid && head.last;

  // State register.
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else     state <= state_next;

  // Next state, issue decision and status outputs.
  always_comb begin
    state_next = state;
    issue      = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: if (start) begin issue = 1'b1; state_next = RUN; end
      RUN: begin
        busy = 1'b1;
        if (issued_all) state_next = DRAIN;
        else if (can_issue) begin
          issue = 1'b1;
          if (last_beat && last_win) state_next = DRAIN;
        end
      end
      DRAIN: begin
        busy = 1'b1;
        if (!vld_pipe[0] && (cnt_next == 2'd0)) state_next = DONE;
      end
      DONE: begin done = 1'b1; state_next = IDLE; end
      default: state_next = IDLE;
    endcase
  end

  // Window/tap walk: taps advance by two per issued beat, windows wrap with no bubble.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      base_q <= '0; wx <= '0; wy <= '0; tap0 <= '0; j <= '0; issued_all <= 1'b0;
    end else begin
      if (state == IDLE && start) base_q <= base_addr;
      if (state == DONE) issued_all <= 1'b0;
      else if (issue && last_beat && last_win) issued_all <= 1'b1;
      if (issue) begin
        if (last_beat) begin
          j <= '0; tap0 <= '0;
          if (wx == CW'(WX_LAST)) begin
            wx <= '0;
            wy <= (wy == CW'(WY_LAST)) ? '0 : wy + 1'b1;
          end else wx <= wx + 1'b1;
        end else begin
          j    <= j + 1'b1;
          tap0 <= tap_inc(lane_tap[1]);
        end
      end
    end

  // Registered read addresses plus per-beat metadata that rides alongside the read.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      read_addr_a <= '0; read_addr_b <= '0; vld_pipe <= '0; meta_pipe <= '0;
    end else begin
      vld_pipe  <= {vld_pipe[STAGES-1:0], issue};
      meta_pipe <= {meta_pipe[STAGES-1:0], {bv_cur, last_beat, lane_oob[0], lane_oob[1]}};
      if (issue) begin
        read_addr_a <= lane_addr[0];
        read_addr_b <= lane_addr[1];
      end
    end

  // 2-entry output FIFO; issue throttling guarantees it never overflows.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      fifo <= '0; wr_ptr <= 1'b0; rd_ptr <= 1'b0; cnt <= 2'd0;
    end else begin
      if (push) begin fifo[wr_ptr] <= land; wr_ptr <= ~wr_ptr; end
      if (spop) rd_ptr <= ~rd_ptr;
      cnt <= cnt_next;
    end
endmodule

// File: tb/tb_conv_window_fetch.sv
// Bench for conv_window_fetch: 8x8 image, K=3, directed runs with random
// stalls/bases against a window-walk reference model.
module tb_conv_window_fetch;
  localparam int AW = 16, DW = 18, W = 8, H = 8, KK = 3;
  localparam int BEATS = (KK * KK + 1) / 2;
  typedef logic [2*DW+1:0] beat_t;

  logic clk = 1'b0, rst, start, out_ready;
  logic [AW-1:0] base_addr, read_addr_a, read_addr_b;
  logic [DW-1:0] read_data_a, read_data_b, out_a, out_b;
  logic out_valid, out_b_valid, out_wlast, busy, done;
  int nassert = 0, nfail = 0, salt = 0;
  beat_t expq[$];
  beat_t first_beat;

  always #5 clk = ~clk;

  conv_window_fetch #(.ADDR_W(AW), .DATA_W(DW), .IMG_W(W), .IMG_H(H), .K(KK)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
    .read_addr_a(read_addr_a), .read_addr_b(read_addr_b),
    .read_data_a(read_data_a), .read_data_b(read_data_b),
    .out_valid(out_valid), .out_ready(out_ready), .out_a(out_a), .out_b(out_b),
    .out_b_valid(out_b_valid), .out_wlast(out_wlast), .busy(busy), .done(done));

  function automatic logic [DW-1:0] memf(input logic [AW-1:0] a);
    return DW'(int'(a) * 10 + salt);
  endfunction

  // Image memory: one-cycle synchronous read on both ports.
  always @(posedge clk) begin
    read_data_a <= memf(read_addr_a);
    read_data_b <= memf(read_addr_b);
  end

  function automatic void tap_ref(input logic [AW-1:0] b, input int wy, input int wx, input int t,
                                  output logic [AW-1:0] addr, output logic [DW-1:0] val);
    int off, r, c;
`ifdef WINDOW_PAD_EN
    off = KK / 2;
`else
    off = 0;
`endif
    r = wy + t / KK - off;
    c = wx + t % KK - off;
    addr = AW'(int'(b) + r * W + c);
    if (r < 0 || r >= H || c < 0 || c >= W) val = '0;
    else val = memf(addr);
  endfunction

  function automatic void build_model(input logic [AW-1:0] b);
    int nwy, nwx;
    logic [AW-1:0] ad;
    logic [DW-1:0] va, vb;
    logic bv;
    expq.delete();
`ifdef WINDOW_PAD_EN
    nwy = H; nwx = W;
`else
    nwy = H - KK + 1; nwx = W - KK + 1;
`endif
    for (int wy = 0; wy < nwy; wy++)
      for (int wx = 0; wx < nwx; wx++)
        for (int jb = 0; jb < BEATS; jb++) begin
          tap_ref(b, wy, wx, 2 * jb, ad, va);
          bv = (2 * jb + 1) < KK * KK;
          if (bv) tap_ref(b, wy, wx, 2 * jb + 1, ad, vb);
          else vb = '0;
          expq.push_back({va, vb, bv, 1'(jb == BEATS - 1)});
        end
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nassert++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic run_image(input logic [AW-1:0] b, input bit rnd, input bit poke);
    int nbeats, nexp, last_hs;
    bit stall, fin, got_first;
    beat_t held, got;
    logic [AW-1:0] a0, a1, a6;
    logic [DW-1:0] dv;
    build_model(b);
    nexp = expq.size(); nbeats = 0; stall = 1'b0; fin = 1'b0; last_hs = 0; got_first = 1'b0;
    held = '0;
    tap_ref(b, 0, 0, 0, a0, dv);
    tap_ref(b, 0, 0, 1, a1, dv);
    tap_ref(b, 0, 0, 6, a6, dv);
    @(posedge clk); #1; start = 1'b1; base_addr = b; out_ready = 1'b1;
    @(posedge clk); #1; start = 1'b0; base_addr = ~b;
    for (int cyc = 1; cyc < 4000 && !fin; cyc++) begin
      out_ready = rnd ? 1'($urandom % 2) : 1'b1;
      if (poke) start = ($urandom % 6) == 0;
      @(negedge clk);
      got = {out_a, out_b, out_b_valid, out_wlast};
      if (cyc == 1) begin
        chk("addr_a_first", 64'(read_addr_a), 64'(a0));
        chk("addr_b_first", 64'(read_addr_b), 64'(a1));
        chk("valid_cycle1", 64'(out_valid), 64'(0));
      end
      if (cyc == 2) chk("valid_cycle2", 64'(out_valid), 64'(1));
      if (cyc == 4 && !rnd) chk("addr_tap6", 64'(read_addr_a), 64'(a6));
      if (stall) chk("stall_hold", 64'({out_valid, got}), 64'({1'b1, held}));
      if (!done) chk("busy_high", 64'(busy), 64'(1));
      if (out_valid && out_ready) begin
        if (!got_first) begin first_beat = got; got_first = 1'b1; end
        if (expq.size() == 0) chk("extra_beat", 64'(1), 64'(0));
        else chk("beat", 64'(got), 64'(expq.pop_front()));
        nbeats++;
        last_hs = cyc;
      end
      stall = out_valid && !out_ready;
      held = got;
      if (done) begin
        fin = 1'b1;
        chk("done_busy_low", 64'(busy), 64'(0));
        chk("done_beat_count", 64'(nbeats), 64'(nexp));
        chk("done_latency", 64'(cyc - last_hs), 64'(1));
      end
      @(posedge clk); #1;
    end
    start = 1'b0; out_ready = 1'b1;
    chk("done_seen", 64'(fin), 64'(1));
    repeat (3) begin
      @(negedge clk);
      chk("done_single", 64'(done), 64'(0));
      chk("idle_no_valid", 64'(out_valid), 64'(0));
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; out_ready = 1'b0; base_addr = '0;
    #12;
    chk("rst_state", 64'({busy, done, out_valid, out_b_valid, out_wlast}), 64'(0));
    chk("rst_out", 64'({out_a, out_b}), 64'(0));
    chk("rst_addr", 64'({read_addr_a, read_addr_b}), 64'(0));
    @(posedge clk); #1; rst = 1'b0;

    salt = 0;
    run_image(16'd100, 1'b0, 1'b0);
`ifndef WINDOW_PAD_EN
    chk("plan_first_beat", 64'(first_beat), 64'({18'd1000, 18'd1010, 1'b1, 1'b0}));
`endif
    run_image(16'd100, 1'b1, 1'b0);
    salt = 3;
    run_image(16'd65530, 1'b0, 1'b0);
    salt = 5;
    run_image(AW'($urandom), 1'b1, 1'b1);

    // Mid-image reset then restart from base 0.
    @(posedge clk); #1; start = 1'b1; base_addr = 16'd7; out_ready = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (20) @(posedge clk);
    #2; rst = 1'b1; #1;
    chk("midrst_valid", 64'(out_valid), 64'(0));
    chk("midrst_busy", 64'(busy), 64'(0));
    chk("midrst_addr", 64'(read_addr_a), 64'(0));
    @(posedge clk); #1; rst = 1'b0;
    repeat (4) begin @(negedge clk); chk("post_rst_quiet", 64'(out_valid), 64'(0)); end
    salt = 0;
    run_image(16'd0, 1'b0, 1'b0);
`ifndef WINDOW_PAD_EN
    chk("restart_first_beat", 64'(first_beat), 64'({18'd0, 18'd10, 1'b1, 1'b0}));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", nassert, nfail);
    $finish;
  end
endmodule

// File: doc/conv_window_fetch.md
Name: conv_window_fetch

Overview:
Upstream reader for the image memory. It walks a row-major image stored at base_addr and issues paired reads on the memory's two read ports. The 1-cycle read data is re-timed into a K×K sliding-window tap stream (stride 1), two taps per beat, with a valid/ready handshake toward the convolution datapath. One start produces the complete set of windows for one image.

Parameters:
ADDR_W, 16, memory address width
DATA_W, 18, memory word / tap width
IMG_W, 32, image width in pixels (>= K)
IMG_H, 32, image height in pixels (>= K)
K, 3, window edge (1..7)

Ports:
clk  in  1  rising-edge clock
rst  in  1  asynchronous, active-high reset
start  in  1  one-cycle pulse; sampled only in IDLE
base_addr  in  ADDR_W  address of pixel (0,0); latched on accepted start
read_addr_a  out  ADDR_W  memory port A read address, registered
read_addr_b  out  ADDR_W  memory port B read address, registered
read_data_a  in  DATA_W  memory port A data; valid the cycle after the address is presented
read_data_b  in  DATA_W  memory port B data; same timing as port A
out_valid  out  1  beat available
out_ready  in  1  consumer accepts the beat when out_valid && out_ready
out_a  out  DATA_W  even tap of the beat
out_b  out  DATA_W  odd tap of the beat
out_b_valid  out  1  out_b carries a real tap
out_wlast  out  1  final beat of the current window
busy  out  1  high from accepted start until done
done  out  1  one-cycle pulse after the last beat of the image is accepted

Behaviour:
- Reset (asynchronous, any time, including mid-image): state=IDLE; all counters, in-flight flag and output buffer cleared. Outputs: read_addr_a/b=0, out_valid=0, out_a/out_b=0, out_b_valid=0, out_wlast=0, busy=0, done=0. No beat is emitted after reset until a new start.
- States:
  - IDLE: start=1 latches base_addr, sets busy, moves to RUN.
  - RUN: issues reads. After the address pair for the final beat of the final window is issued, moves to DRAIN.
  - DRAIN: waits until the in-flight read has landed and the buffer has emptied, then moves to DONE.
  - DONE: pulses done for one cycle, clears busy, returns to IDLE.
- start while not in IDLE is ignored.
- Window order: wy=0..IMG_H-K outer, wx=0..IMG_W-K inner. Total windows = (IMG_W-K+1)*(IMG_H-K+1).
- Tap order within a window: t=0..K*K-1, with ky=t/K and kx=t%K.
- Tap address = base + (wy+ky)*IMG_W + wx + kx, computed modulo 2^ADDR_W (wrap permitted, no error).
- Beat j of a window carries tap 2j on A and tap 2j+1 on B. Beats per window = ceil(K*K/2).
- When K*K is odd, the last beat has out_b_valid=0 and out_b=0; out_wlast=1 on that beat. Otherwise out_wlast=1 on the beat carrying tap K*K-1.
- Read timing: an address pair issued in cycle n has its data captured in cycle n+1 into a 2-entry output FIFO.
- Issue rule: issue a pair only if FIFO occupancy + in-flight count < 2. A full FIFO with out_ready=0 therefore never overflows and never drops data.
- out_valid=1 whenever the FIFO is non-empty. Beat fields stay stable while out_valid && !out_ready.
- Simultaneous pop and capture in one cycle is legal; occupancy is unchanged.
- With out_ready held high, throughput is 1 beat/cycle after a 2-cycle start latency: start in cycle 0, first address pair in cycle 1, first out_valid in cycle 2.
- Counters wrap (kx→ky→wx→wy) with no idle bubbles between windows.
- done is asserted in the cycle after the final handshake; busy falls in that same cycle.

Optional Feature:
WINDOW_PAD_EN. When defined, the block uses "same" padding:
- Windows are centred on every pixel: wy=0..IMG_H-1, wx=0..IMG_W-1, tap offset -(K/2)..+(K/2).
- A tap whose row or column falls outside the image yields 0.
- Out-of-image taps still occupy their beat slot but do not change read timing; the address is driven but its data is replaced by 0.
When not defined, there is no padding: only valid windows are produced, exactly as specified above. The port list is identical in both builds.

Test Plan:
- IMG_W=IMG_H=8, K=3, base=100, mem[i]=i*10, out_ready=1. Window 0 beats: (1000,1010), (1020,1080), (1090,1100), (1160,1170), (1180,b_valid=0,wlast=1). Window 1 starts with (1010,1020). Exactly 180 beats, then a single done pulse.
- Same setup with out_ready toggling 1,0,0,1 pseudo-randomly: beat sequence identical to the previous run, no beat dropped or duplicated, fields stable while stalled.
- base=65530, IMG_W=8: tap addresses wrap to 0,1,... Window 0 tap 6 read address = (65530+16) mod 65536 = 10.
- Assert rst for 1 cycle mid-image: out_valid=0, busy=0 immediately. A new start with base=0 gives a first beat of (mem[0], mem[1]).
- start pulses while busy: ignored, beat count unchanged. done pulses exactly once per accepted start.
- WINDOW_PAD_EN, 4×4 image, K=3, base=0: 16 windows. Window 0 taps 0,1,2,3,6 = 0; tap 4 = mem[0]; tap 8 = mem[5].
